// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out receiver: rebuilds MSB-first WIDTH-bit words from a PISO stream and
// hands them off through a valid/ready holding register. Optional parity: SIPO_PARITY_CHECK_EN.
module sipo_deserializer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_in,
   input  logic             s_empty,
   input  logic             p_ready,
   output logic [WIDTH-1:0] p_out,
   output logic             p_valid,
   output logic             busy,
   output logic             overrun,
   output logic             parity_err
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

   state_t           state;
   logic [WIDTH-1:0] shift_q;
   logic [CNT_W-1:0] bit_cnt;
   logic             sample;
   logic             last_data;
   logic             complete;
   logic [WIDTH-1:0] word;
   logic             word_perr;

`ifdef SIPO_PARITY_CHECK_EN
   function automatic logic parity_check(input logic [WIDTH-1:0] w, input logic pbit);
      return (^w) ^ pbit;
   endfunction
`endif

   assign sample    = !s_empty;
   assign last_data = (state == SHIFT) && (bit_cnt == CNT_W'(WIDTH - 1));
   assign busy      = (state != IDLE);

   always_comb begin
      complete  = 1'b0;
      word      = {shift_q[WIDTH-2:0], s_in};
      word_perr = 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
      // The data bits already sit in shift_q; s_in now carries the parity bit.
      if (sample && state == PARITY) begin
         complete  = 1'b1;
         word      = shift_q;
         word_perr = parity_check(shift_q, s_in);
      end
`else
      complete = sample && last_data;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         shift_q    <= '0;
         bit_cnt    <= '0;
         p_out      <= '0;
         p_valid    <= 1'b0;
         overrun    <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         if (sample) begin
            case (state)
               IDLE: begin
                  shift_q <= {{(WIDTH-1){1'b0}}, s_in};
                  bit_cnt <= CNT_W'(1);
                  state   <= SHIFT;
               end
               SHIFT: begin
                  shift_q <= {shift_q[WIDTH-2:0], s_in};
                  if (last_data) begin
                     bit_cnt <= '0;
`ifdef SIPO_PARITY_CHECK_EN
                     state   <= PARITY;
`else
                     state   <= IDLE;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end

         // A held, unaccepted word wins over a newly completed one.
         if (complete) begin
            if (p_valid && !p_ready) begin
               overrun <= 1'b1;
            end else begin
               p_out      <= word;
               p_valid    <= 1'b1;
               parity_err <= word_perr;
            end
         end else if (p_valid && p_ready) begin
            p_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer: scoreboard of expected words plus per-scenario tasks.
// Follows SIPO_PARITY_CHECK_EN so frames carry a parity bit when the DUT does.
module tb_sipo_deserializer;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         s_in;
   logic         s_empty;
   logic         p_ready;
   logic [W-1:0] p_out;
   logic         p_valid;
   logic         busy;
   logic         overrun;
   logic         parity_err;

   int checks   = 0;
   int failures = 0;
   logic [W-1:0] exp_q[$];

   sipo_deserializer #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .s_in(s_in), .s_empty(s_empty), .p_ready(p_ready),
      .p_out(p_out), .p_valid(p_valid), .busy(busy), .overrun(overrun), .parity_err(parity_err)
   );

   always #5 clk = ~clk;

   // Inputs change only #1 after posedge, so values seen here are those of the next edge.
   always @(negedge clk) begin
      if (!rst && p_valid && p_ready) begin
         logic [W-1:0] exp_w;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected_word got=%b expected none", p_out);
         end else begin
            exp_w = exp_q.pop_front();
            if (p_out !== exp_w) begin
               failures++;
               $display("FAIL sb_word got=%b expected=%b", p_out, exp_w);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic send_bit(input logic b);
      s_in    = b;
      s_empty = 1'b0;
      @(posedge clk);
      #1;
      s_empty = 1'b1;
   endtask

   task automatic idle_cycle();
      s_empty = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // rdy_last is applied before the completing edge; flip corrupts the parity bit.
   task automatic send_word(input logic [W-1:0] w, input logic rdy_last, input logic flip);
      for (int i = W - 1; i >= 0; i--) begin
`ifndef SIPO_PARITY_CHECK_EN
         if (i == 0) p_ready = rdy_last;
`endif
         send_bit(w[i]);
      end
`ifdef SIPO_PARITY_CHECK_EN
      p_ready = rdy_last;
      send_bit((^w) ^ flip);
`endif
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_reset();
      checks++;
      if ({p_out, p_valid, busy, overrun, parity_err} !== '0) begin
         failures++;
         $display("FAIL reset_init got=%b expected=0", {p_out, p_valid, busy, overrun, parity_err});
      end
      rst = 1'b0;
      p_ready = 1'b1;
      send_bit(1'b1);
      send_bit(1'b0);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL reset_busy_mid got=%b expected=1", busy);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({p_out, p_valid, busy, overrun, parity_err} !== '0) begin
         failures++;
         $display("FAIL reset_async got=%b expected=0", {p_out, p_valid, busy, overrun, parity_err});
      end
      @(posedge clk);
      #1 rst = 1'b0;
      exp_q.push_back(4'b1101);
      send_word(4'b1101, 1'b1, 1'b0);
      checks++;
      if (p_valid !== 1'b1 || p_out !== 4'b1101) begin
         failures++;
         $display("FAIL reset_next_word got=%b/%b expected=1/1101", p_valid, p_out);
      end
      idle_cycle();
   endtask

   task automatic test_basic();
      p_ready = 1'b1;
      exp_q.push_back(4'b1101);
      send_word(4'b1101, 1'b1, 1'b0);
      checks++;
      if (p_valid !== 1'b1 || p_out !== 4'b1101 || busy !== 1'b0) begin
         failures++;
         $display("FAIL basic_word got=%b/%b/%b expected=1/1101/0", p_valid, p_out, busy);
      end
      idle_cycle();
      checks++;
      if (p_valid !== 1'b0) begin
         failures++;
         $display("FAIL basic_valid_drop got=%b expected=0", p_valid);
      end
   endtask

   task automatic test_pause();
      p_ready = 1'b1;
      exp_q.push_back(4'b1011);
      send_bit(1'b1);
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) begin
         idle_cycle();
         checks++;
         if (busy !== 1'b1 || p_valid !== 1'b0) begin
            failures++;
            $display("FAIL pause_gap%0d got=%b/%b expected=1/0", i, busy, p_valid);
         end
      end
      send_bit(1'b1);
      send_bit(1'b1);
`ifdef SIPO_PARITY_CHECK_EN
      send_bit(1'b1);
`endif
      checks++;
      if (p_valid !== 1'b1 || p_out !== 4'b1011) begin
         failures++;
         $display("FAIL pause_word got=%b/%b expected=1/1011", p_valid, p_out);
      end
      idle_cycle();
   endtask

   task automatic test_simultaneous();
      p_ready = 1'b0;
      exp_q.push_back(4'b1010);
      send_word(4'b1010, 1'b0, 1'b0);
      checks++;
      if (p_valid !== 1'b1 || p_out !== 4'b1010) begin
         failures++;
         $display("FAIL simul_first got=%b/%b expected=1/1010", p_valid, p_out);
      end
      exp_q.push_back(4'b0110);
      send_word(4'b0110, 1'b1, 1'b0);
      checks++;
      if (p_valid !== 1'b1 || p_out !== 4'b0110 || overrun !== 1'b0) begin
         failures++;
         $display("FAIL simul_second got=%b/%b/%b expected=1/0110/0", p_valid, p_out, overrun);
      end
      idle_cycle();
      idle_cycle();
      checks++;
      if (p_valid !== 1'b0 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL simul_drain got=%b/%0d expected=0/0", p_valid, exp_q.size());
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] w;
      p_ready = 1'b1;
      for (int n = 0; n < 8; n++) begin
         w = W'($urandom_range(0, (1 << W) - 1));
         exp_q.push_back(w);
         send_word(w, 1'b1, 1'b0);
      end
      idle_cycle();
      idle_cycle();
      checks++;
      if (exp_q.size() != 0 || p_valid !== 1'b0 || overrun !== 1'b0) begin
         failures++;
         $display("FAIL b2b_drain got=%0d/%b/%b expected=0/0/0", exp_q.size(), p_valid, overrun);
      end
   endtask

   task automatic test_backpressure();
      p_ready = 1'b0;
      exp_q.push_back(4'b1101);
      send_word(4'b1101, 1'b0, 1'b0);
      send_word(4'b0000, 1'b0, 1'b0);
      checks++;
      if (p_valid !== 1'b1 || p_out !== 4'b1101 || overrun !== 1'b1) begin
         failures++;
         $display("FAIL bp_hold got=%b/%b/%b expected=1/1101/1", p_valid, p_out, overrun);
      end
      p_ready = 1'b1;
      idle_cycle();
      checks++;
      if (p_valid !== 1'b0 || overrun !== 1'b1 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL bp_release got=%b/%b/%0d expected=0/1/0", p_valid, overrun, exp_q.size());
      end
      do_reset();
      checks++;
      if (overrun !== 1'b0) begin
         failures++;
         $display("FAIL bp_overrun_clear got=%b expected=0", overrun);
      end
   endtask

`ifdef SIPO_PARITY_CHECK_EN
   task automatic test_parity();
      p_ready = 1'b1;
      exp_q.push_back(4'b1101);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      checks++;
      if (p_valid !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL parity_wait got=%b/%b expected=0/1", p_valid, busy);
      end
      send_bit(1'b1);
      checks++;
      if (p_valid !== 1'b1 || parity_err !== 1'b0 || p_out !== 4'b1101) begin
         failures++;
         $display("FAIL parity_good got=%b/%b/%b expected=1/0/1101", p_valid, parity_err, p_out);
      end
      exp_q.push_back(4'b1101);
      send_word(4'b1101, 1'b1, 1'b1);
      checks++;
      if (p_valid !== 1'b1 || parity_err !== 1'b1 || p_out !== 4'b1101) begin
         failures++;
         $display("FAIL parity_bad got=%b/%b/%b expected=1/1/1101", p_valid, parity_err, p_out);
      end
      idle_cycle();
   endtask
`endif

   initial begin
      rst     = 1'b1;
      s_in    = 1'b0;
      s_empty = 1'b1;
      p_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      test_reset();
      test_basic();
      test_pause();
      test_simultaneous();
      test_back_to_back();
      test_backpressure();
`ifdef SIPO_PARITY_CHECK_EN
      test_parity();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
